// File: rtl/note_player_pkg.sv
// Shared types and constants for the note sequencer and its step-size ROM.
package note_player_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    PLAYING = 2'd2
  } state_t;

  localparam int unsigned STEP_W    = 25;
  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned REST_NOTE = 0;

endpackage

// File: rtl/frequency_rom.sv
// 64x25 synchronous ROM of phase step sizes; entry n plays 440*2^((n-49)/12) Hz at 48 kHz.
module frequency_rom
  import note_player_pkg::*;
(
  input  logic              clk,
  input  logic [5:0]        addr,
  output logic [STEP_W-1:0] dout
);

  logic [STEP_W-1:0] rom_word;

  always_comb begin
    rom_word = '0;
    case (addr)
      6'd1:  rom_word = 25'd2403;
      6'd2:  rom_word = 25'd2546;
      6'd3:  rom_word = 25'd2697;
      6'd4:  rom_word = 25'd2858;
      6'd5:  rom_word = 25'd3028;
      6'd6:  rom_word = 25'd3208;
      6'd7:  rom_word = 25'd3398;
      6'd8:  rom_word = 25'd3600;
      6'd9:  rom_word = 25'd3815;
      6'd10: rom_word = 25'd4041;
      6'd11: rom_word = 25'd4282;
      6'd12: rom_word = 25'd4536;
      6'd13: rom_word = 25'd4806;
      6'd14: rom_word = 25'd5092;
      6'd15: rom_word = 25'd5395;
      6'd16: rom_word = 25'd5715;
      6'd17: rom_word = 25'd6055;
      6'd18: rom_word = 25'd6415;
      6'd19: rom_word = 25'd6797;
      6'd20: rom_word = 25'd7201;
      6'd21: rom_word = 25'd7629;
      6'd22: rom_word = 25'd8083;
      6'd23: rom_word = 25'd8563;
      6'd24: rom_word = 25'd9072;
      6'd25: rom_word = 25'd9612;
      6'd26: rom_word = 25'd10184;
      6'd27: rom_word = 25'd10789;
      6'd28: rom_word = 25'd11431;
      6'd29: rom_word = 25'd12110;
      6'd30: rom_word = 25'd12830;
      6'd31: rom_word = 25'd13593;
      6'd32: rom_word = 25'd14402;
      6'd33: rom_word = 25'd15258;
      6'd34: rom_word = 25'd16165;
      6'd35: rom_word = 25'd17127;
      6'd36: rom_word = 25'd18145;
      6'd37: rom_word = 25'd19224;
      6'd38: rom_word = 25'd20367;
      6'd39: rom_word = 25'd21578;
      6'd40: rom_word = 25'd22861;
      6'd41: rom_word = 25'd24221;
      6'd42: rom_word = 25'd25661;
      6'd43: rom_word = 25'd27187;
      6'd44: rom_word = 25'd28803;
      6'd45: rom_word = 25'd30516;
      6'd46: rom_word = 25'd32331;
      6'd47: rom_word = 25'd34253;
      6'd48: rom_word = 25'd36290;
      6'd49: rom_word = 25'd38448;
      6'd50: rom_word = 25'd40734;
      6'd51: rom_word = 25'd43156;
      6'd52: rom_word = 25'd45722;
      6'd53: rom_word = 25'd48441;
      6'd54: rom_word = 25'd51322;
      6'd55: rom_word = 25'd54373;
      6'd56: rom_word = 25'd57607;
      6'd57: rom_word = 25'd61032;
      6'd58: rom_word = 25'd64661;
      6'd59: rom_word = 25'd68506;
      6'd60: rom_word = 25'd72580;
      6'd61: rom_word = 25'd76896;
      6'd62: rom_word = 25'd81468;
      6'd63: rom_word = 25'd86312;
      default: rom_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    dout <= rom_word;
  end

endmodule

// File: rtl/note_player.sv
// Per-note sequencer: latches a note, looks up its step size, gates codec requests
// to the sine reader, counts beats, and returns muted or live samples 3 cycles later.
module note_player
  import note_player_pkg::*;
#(
  parameter int unsigned DUR_W  = 6,
  parameter int unsigned NOTE_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                play_enable,
  input  logic                load_new_note,
  input  logic [NOTE_W-1:0]   note,
  input  logic [DUR_W-1:0]    duration,
  input  logic                beat,
  input  logic                generate_next_sample,
  input  logic [SAMPLE_W-1:0] sine_sample,
  output logic [STEP_W-1:0]   step_size,
  output logic                generate_next,
  output logic                phase_reset,
  output logic                note_done,
  output logic                busy,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                new_sample_ready
);

  state_t              state, state_next;
  logic [NOTE_W-1:0]   note_q;
  logic [NOTE_W-1:0]   rom_addr;
  logic [DUR_W-1:0]    count_q;
  logic [STEP_W-1:0]   step_size_q;
  logic [STEP_W-1:0]   rom_dout;
  logic                live_beat;
  logic                final_beat;
  logic                done_q;
  logic                mute_now;
  logic                req1, mute1, req2, mute2;
  logic                ready_q;
  logic [SAMPLE_W-1:0] sample_q;

  // Address the incoming note on the load cycle so the word is ready in LOOKUP.
  assign rom_addr = load_new_note ? note : note_q;

  frequency_rom u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .dout (rom_dout)
  );

  assign live_beat = (state == PLAYING) && beat && play_enable;

  always_comb begin
    state_next = state;
    final_beat = 1'b0;
    unique case (state)
      IDLE:    if (load_new_note) state_next = LOOKUP;
      LOOKUP:  state_next = load_new_note ? LOOKUP : PLAYING;
      PLAYING: begin
        if (load_new_note) begin
          state_next = LOOKUP;
        end else if (live_beat && (count_q == DUR_W'(1))) begin
          state_next = IDLE;
          final_beat = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // A duration of 0 wraps through 63 on the first beat, giving 64 beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note_q  <= '0;
      count_q <= '0;
    end else if (load_new_note) begin
      note_q  <= note;
      count_q <= duration;
    end else if (live_beat) begin
      count_q <= count_q - DUR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 step_size_q <= '0;
    else if (state == LOOKUP)   step_size_q <= rom_dout;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) done_q <= 1'b0;
    else        done_q <= final_beat;
  end

  assign mute_now = !((state == PLAYING) && play_enable && (note_q != NOTE_W'(REST_NOTE)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req1     <= 1'b0;
      mute1    <= 1'b1;
      req2     <= 1'b0;
      mute2    <= 1'b1;
      ready_q  <= 1'b0;
      sample_q <= '0;
    end else begin
      req1    <= generate_next_sample;
      mute1   <= mute_now;
      req2    <= req1;
      mute2   <= mute1;
      ready_q <= req2;
      if (req2) sample_q <= mute2 ? '0 : sine_sample;
    end
  end

  assign step_size        = step_size_q;
  assign generate_next    = generate_next_sample && (state == PLAYING) && play_enable;
  assign phase_reset      = (state == LOOKUP);
  assign note_done        = done_q;
  assign busy             = (state != IDLE);
  assign sample_out       = sample_q;
  assign new_sample_ready = ready_q;

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: directed scenarios plus random traffic against a beat/queue model.
module tb_note_player;

  logic        clk = 1'b0;
  logic        reset;
  logic        play_enable;
  logic        load_new_note;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        beat;
  logic        generate_next_sample;
  logic [15:0] sine_sample;
  logic [24:0] step_size;
  logic        generate_next;
  logic        phase_reset;
  logic        note_done;
  logic        busy;
  logic [15:0] sample_out;
  logic        new_sample_ready;

  int errors = 0;
  int checks = 0;

  // Reference model: note lifetime in beats, cycles since load, pending requests.
  bit m_active;
  int m_age;
  int m_beats;
  int m_note;
  int m_step;
  int m_sample;
  bit m_ready;
  bit m_done;
  int cyc;
  int q_cyc[$];
  bit q_mute[$];

  note_player #(.DUR_W(6), .NOTE_W(6)) dut (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .load_new_note        (load_new_note),
    .note                 (note),
    .duration             (duration),
    .beat                 (beat),
    .generate_next_sample (generate_next_sample),
    .sine_sample          (sine_sample),
    .step_size            (step_size),
    .generate_next        (generate_next),
    .phase_reset          (phase_reset),
    .note_done            (note_done),
    .busy                 (busy),
    .sample_out           (sample_out),
    .new_sample_ready     (new_sample_ready)
  );

  always #5 clk = ~clk;

  function automatic int rom_ref(input int n);
    real f;
    if (n == 0) return 0;
    f = 440.0 * $pow(2.0, (real'(n) - 49.0) / 12.0) * 4194304.0 / 48000.0;
    return $rtoi(f + 0.5);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("busy",        32'(busy),             32'(m_active));
    chk("phase_reset", 32'(phase_reset),      32'(m_active && m_age == 1));
    chk("note_done",   32'(note_done),        32'(m_done));
    chk("step_size",   32'(step_size),        32'(m_step));
    chk("ready",       32'(new_sample_ready), 32'(m_ready));
    chk("sample_out",  32'(sample_out),       32'(m_sample[15:0]));
  endtask

  task automatic model_clear();
    m_active = 0; m_age = 0; m_beats = 0; m_note = 0; m_step = 0;
    m_sample = 0; m_ready = 0; m_done = 0;
    q_cyc.delete();
    q_mute.delete();
  endtask

  task automatic step(input bit ld, input int nt, input int du,
                      input bit bt, input bit en, input bit gn);
    bit pl, lk;
    load_new_note        = ld;
    note                 = 6'(nt);
    duration             = 6'(du);
    beat                 = bt;
    play_enable          = en;
    generate_next_sample = gn;
    sine_sample          = 16'($urandom);
    pl = m_active && m_age >= 2;
    lk = m_active && m_age == 1;
    #1;
    chk("generate_next", 32'(generate_next), 32'(gn && pl && en));
    @(posedge clk);
    if (lk) m_step = rom_ref(m_note);
    m_done  = 0;
    m_ready = 0;
    if (gn) begin
      q_cyc.push_back(cyc);
      q_mute.push_back(!(pl && en && m_note != 0));
    end
    if (q_cyc.size() > 0 && q_cyc[0] == cyc - 2) begin
      m_ready  = 1;
      m_sample = q_mute[0] ? 0 : int'(sine_sample);
      void'(q_cyc.pop_front());
      void'(q_mute.pop_front());
    end
    if (ld) begin
      m_active = 1;
      m_age    = 1;
      m_note   = nt;
      m_beats  = (du == 0) ? 64 : du;
    end else if (m_active) begin
      if (pl && bt && en) begin
        if (m_beats == 1) begin
          m_active = 0;
          m_done   = 1;
        end else begin
          m_beats--;
        end
      end
      m_age++;
    end
    cyc++;
    #1;
    chk_outputs();
  endtask

  task automatic idle(input int n, input bit en, input bit gn);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, en, gn);
  endtask

  task automatic do_reset();
    load_new_note = 0; beat = 0; generate_next_sample = 0; play_enable = 0;
    reset = 1'b0;
    #1;
    model_clear();
    chk_outputs();
    chk("rst_gen_next", 32'(generate_next), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    play_enable = 0; load_new_note = 0; note = '0; duration = '0;
    beat = 0; generate_next_sample = 0; sine_sample = '0;
    model_clear();
    cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs();
    chk("rst_gen_next", 32'(generate_next), 32'd0);
    reset = 1'b1;

    // Requests with no note loaded are answered with silence.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, 1);
      idle(1, 1, 0);
    end
    idle(4, 1, 0);

    // Note 49, two beats.
    step(1, 49, 2, 0, 1, 0);
    idle(2, 1, 1);
    chk("rom49", 32'(step_size), 32'd38448);
    step(0, 0, 0, 1, 1, 1);
    idle(2, 1, 1);
    step(0, 0, 0, 1, 1, 0);
    idle(4, 1, 0);

    // Paused beats are not counted; paused requests come back muted.
    step(1, 49, 3, 0, 1, 0);
    idle(2, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 0, 1);
      idle(1, 0, 1);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 1, 1);
      idle(1, 1, 1);
    end
    idle(4, 1, 0);

    // Rest note.
    step(1, 0, 1, 0, 1, 0);
    idle(3, 1, 1);
    step(0, 0, 0, 1, 1, 1);
    idle(4, 1, 0);

    // Duration 0 means 64 beats.
    step(1, 10, 0, 0, 1, 0);
    idle(2, 1, 0);
    for (int i = 0; i < 64; i++) begin
      step(0, 0, 0, 1, 1, (i % 8) == 0);
      idle(1, 1, 0);
    end
    idle(3, 1, 0);

    // Reload mid-note, and reload on the final beat.
    step(1, 20, 3, 0, 1, 0);
    idle(2, 1, 0);
    step(0, 0, 0, 1, 1, 1);
    step(1, 61, 2, 1, 1, 1);
    idle(2, 1, 1);
    step(0, 0, 0, 1, 1, 0);
    step(1, 30, 1, 0, 1, 0);
    step(1, 45, 2, 0, 1, 0);
    idle(2, 1, 0);
    step(1, 61, 2, 1, 1, 0);
    idle(2, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    idle(3, 1, 0);

    // Reset mid-note with samples in flight.
    step(1, 33, 5, 0, 1, 0);
    idle(2, 1, 0);
    step(0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    do_reset();
    idle(5, 1, 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 63), $urandom_range(0, 7),
           $urandom_range(0, 3) == 0, $urandom_range(0, 5) != 0, $urandom_range(0, 1) == 1);
    end
    idle(4, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
